parity_frame_rx: RTL and testbench

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_pkg.sv | 16 +
 rtl/parity_xor.sv | 15 +
 rtl/parity_frame_rx.sv | 119 +++++++++++
 tb/tb_parity_frame_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity-framed serial receiver and transmitter.
package parity_pkg;

    localparam int   DATA_W_DEF = 7;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/parity_xor.sv
// XOR-reduce of a data word (even-parity generator/checker).
// Latency: combinational.
// Backpressure: none.
module parity_xor
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] din,
    output logic              par
);

    assign par = ^din;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Latency: out_valid rises 1 cycle after the stop beat is accepted.
// Backpressure: rx_ready drops while a completed frame waits for out_ready.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_q, par_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               data_xor;
    logic               accept;

    parity_xor #(.DATA_W(DATA_W)) u_parity_xor (
        .din (shift_q),
        .par (data_xor)
    );

    assign accept = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && rx_bit == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    shift_d[cnt_q] = rx_bit;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    par_d   = rx_bit;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Visible outputs are only ever updated here, so they stay stable through HOLD.
                if (accept) begin
                    data_d  = shift_q;
                    perr_d  = data_xor ^ par_q;
                    ferr_d  = (rx_bit != STOP_BIT);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = (state_q != ST_HOLD);
        out_valid = (state_q == ST_HOLD);
    end

    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: vector table plus hold and mid-frame reset sequences.
module tb_parity_frame_rx;

    localparam int DATA_W = 7;

    logic              clk;
    logic              rst_n;
    logic              rx_bit;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] data_out;
    logic              parity_err;
    logic              frame_err;
    logic              out_valid;
    logic              out_ready;

    parity_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              p;
        logic              s;
        int                gap;
        logic [DATA_W-1:0] exp_d;
        logic              exp_pe;
        logic              exp_fe;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              pe;
        logic              fe;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rx_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
    endtask

    // Drives the first nbeats beats of a frame; the stop beat is the last of DATA_W+3.
    task automatic send_beats(input logic [DATA_W-1:0] d, input logic p, input logic s,
                              input int gap, input int nbeats);
        logic [DATA_W+2:0] beats;
        beats = {s, p, d, 1'b0};
        for (int i = 0; i < nbeats; i++) begin
            rx_bit   = beats[i];
            rx_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_bit   = 1'b1;
            if (i == DATA_W + 2) check("latency_out_valid", 32'(out_valid), 32'd1);
            else                 check("no_early_valid", 32'(out_valid), 32'd0);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s, input int gap,
                              input logic [DATA_W-1:0] exp_d, input logic exp_pe, input logic exp_fe);
        exp_t e;
        e.d  = exp_d;
        e.pe = exp_pe;
        e.fe = exp_fe;
        sb.push_back(e);
        send_beats(d, p, s, gap, DATA_W + 3);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got data %0h with empty scoreboard", data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out",   32'(data_out),   32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err",  32'(frame_err),  32'(e.fe));
            end
        end
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{7'h65, 1'b0, 1'b1, 0, 7'h65, 1'b0, 1'b0};
        vecs[1] = '{7'h65, 1'b1, 1'b1, 0, 7'h65, 1'b1, 1'b0};
        vecs[2] = '{7'h7F, 1'b1, 1'b0, 0, 7'h7F, 1'b0, 1'b1};
        vecs[3] = '{7'h65, 1'b0, 1'b1, 3, 7'h65, 1'b0, 1'b0};
        vecs[4] = '{7'h00, 1'b0, 1'b1, 1, 7'h00, 1'b0, 1'b0};
        vecs[5] = '{7'h2A, 1'b1, 1'b1, 0, 7'h2A, 1'b0, 1'b0};
        vecs[6] = '{7'h01, 1'b0, 1'b0, 2, 7'h01, 1'b1, 1'b1};

        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_bit    = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        rst_n = 1'b1;
        check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].gap,
                       vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
        end
        @(posedge clk); #1;

        // Reset after the 4th data bit: partial frame must vanish without a pulse.
        send_beats(7'h65, 1'b0, 1'b1, 0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out",   32'(data_out),   32'd0);
        check("midrst_parity_err", 32'(parity_err), 32'd0);
        check("midrst_frame_err",  32'(frame_err),  32'd0);
        check("midrst_out_valid",  32'(out_valid),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd1);
        send_frame(7'h7F, 1'b1, 1'b1, 0, 7'h7F, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Consumer stall: bits offered during HOLD must be refused and outputs frozen.
        out_ready = 1'b0;
        send_frame(7'h65, 1'b0, 1'b1, 0, 7'h65, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            rx_valid = 1'b1;
            rx_bit   = 1'b0;
            check("hold_rx_ready",  32'(rx_ready),   32'd0);
            check("hold_out_valid", 32'(out_valid),  32'd1);
            check("hold_data_out",  32'(data_out),   32'h65);
            check("hold_perr",      32'(parity_err), 32'd0);
            @(posedge clk); #1;
        end
        rx_valid  = 1'b0;
        rx_bit    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        send_frame(7'h2A, 1'b0, 1'b1, 0, 7'h2A, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Idle-line ones are discarded before a start bit.
        for (int c = 0; c < 4; c++) begin
            rx_valid = 1'b1;
            rx_bit   = 1'b1;
            @(posedge clk); #1;
            check("idle_ones_ready", 32'(rx_ready),  32'd1);
            check("idle_ones_valid", 32'(out_valid), 32'd0);
        end
        rx_valid = 1'b0;
        send_frame(7'h55, 1'b0, 1'b1, 0, 7'h55, 1'b0, 1'b0);

        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
